// File: rtl/fb_loader.sv
// Double-buffered framebuffer loader: parses SYNC + 2*ROWS data bytes + XOR checksum
// from the uart rx stream, swaps front/back only on a good checksum, and acks or naks.
module fb_loader #(
    parameter int          ROWS    = 80,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter logic [7:0]  ACK     = 8'h06,
    parameter logic [7:0]  NAK     = 8'h15,
    parameter int          TIMEOUT = 24000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_strobe,
    output logic [7:0]  tx_data,
    output logic        tx_strobe,
    input  logic [7:0]  row,
    output logic [15:0] pixels,
    output logic        frame_done,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int IDX_W = $clog2(2 * ROWS);
    localparam int GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * ROWS - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, CSUM} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        csum_q;
    logic [GAP_W-1:0]  gap_q;
    logic              front_q;
    logic [15:0]       buf_a [ROWS];
    logic [15:0]       buf_b [ROWS];
    logic [ROW_W-1:0]  wr_row;
    logic [ROW_W-1:0]  rd_row;
    logic              timed_out;

    assign wr_row    = idx_q[ROW_W:1];
    assign rd_row    = row[ROW_W-1:0];
    assign timed_out = !rx_strobe && (gap_q == GAP_MAX);
    assign busy      = (state_q != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d is defaulted first so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rx_strobe && rx_data == SYNC) state_d = DATA;
            DATA: begin
                if (rx_strobe && idx_q == LAST_IDX) state_d = CSUM;
                else if (timed_out)                 state_d = IDLE;
            end
            CSUM: if (rx_strobe || timed_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            csum_q      <= '0;
            gap_q       <= '0;
            front_q     <= 1'b0;
            tx_data     <= '0;
            tx_strobe   <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            tx_strobe  <= 1'b0;
            frame_done <= 1'b0;
            // Inter-byte gap only matters mid-frame; a strobe always restarts it.
            gap_q <= (state_q == IDLE || rx_strobe) ? '0 : gap_q + GAP_W'(1);
            if (rx_strobe) begin
                case (state_q)
                    IDLE: if (rx_data == SYNC) begin
                        idx_q  <= '0;
                        csum_q <= '0;
                    end
                    DATA: begin
                        idx_q  <= idx_q + IDX_W'(1);
                        csum_q <= csum_q ^ rx_data;
                    end
                    CSUM: begin
                        tx_strobe <= 1'b1;
                        if (rx_data == csum_q) begin
                            tx_data     <= ACK;
                            frame_done  <= 1'b1;
                            front_q     <= ~front_q;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            tx_data <= NAK;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the buffer RAMs are deliberately outside the reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (state_q == DATA && rx_strobe) begin
            if (front_q) begin
                if (idx_q[0]) buf_a[wr_row][7:0]  <= rx_data;
                else          buf_a[wr_row][15:8] <= rx_data;
            end else begin
                if (idx_q[0]) buf_b[wr_row][7:0]  <= rx_data;
                else          buf_b[wr_row][15:8] <= rx_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  pixels <= '0;
        else if (int'(row) >= ROWS) pixels <= '0;
        else if (front_q)           pixels <= buf_b[rd_row];
        else                        pixels <= buf_a[rd_row];
    end

endmodule

// File: tb/tb_fb_loader.sv
// Self-checking bench for fb_loader: a frame-level model of both buffers, front select
// and accepted-frame count predicts tx bytes, swaps and pixel reads.
module tb_fb_loader;

    localparam int ROWS    = 80;
    localparam int TIMEOUT = 24000;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_strobe;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic [7:0]  row;
    logic [15:0] pixels;
    logic        frame_done;
    logic        busy;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    fb_loader dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
        .tx_data(tx_data), .tx_strobe(tx_strobe), .row(row), .pixels(pixels),
        .frame_done(frame_done), .busy(busy), .frame_count(frame_count)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Output pulse monitor; every pulse-cycle counts, so a stretched pulse is visible.
    int         tx_cnt   = 0;
    int         done_cnt = 0;
    logic [7:0] last_tx  = 8'h00;
    always @(negedge clk) begin
        if (tx_strobe) begin
            tx_cnt++;
            last_tx = tx_data;
        end
        if (frame_done) done_cnt++;
    end

    // Frame-level model: buffer contents, which one is shown, and accepted count.
    logic [15:0] mbuf [2][ROWS];
    int          mfront = 0;
    int          mcount = 0;
    logic [7:0]  fr [2*ROWS];

    typedef struct {
        logic [7:0]  r;
        logic [15:0] exp;
    } read_vec_t;
    read_vec_t rvec [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data   = b;
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        tick(gap);
    endtask

    task automatic send_data(input int nbytes, input int gap);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(fr[i], gap);
            if (i % 2 == 0) mbuf[1-mfront][i/2][15:8] = fr[i];
            else            mbuf[1-mfront][i/2][7:0]  = fr[i];
        end
    endtask

    function automatic logic [7:0] frame_xor();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 2*ROWS; i++) x ^= fr[i];
        return x;
    endfunction

    task automatic send_frame(input bit bad, input int gap, input int last_gap);
        send_byte(8'hA5, gap);
        send_data(2*ROWS, gap);
        send_byte(frame_xor() ^ {7'b0, bad}, last_gap);
        if (!bad) begin
            mfront = 1 - mfront;
            mcount = (mcount + 1) % 65536;
        end
    endtask

    task automatic expect_frame(input string name, input int tx0, input int done0,
                                input int exp_n, input logic [7:0] exp_tx, input int exp_done);
        tick(3);
        check({name, "_tx_count"}, tx_cnt - tx0, exp_n);
        check({name, "_tx_data"}, last_tx, exp_tx);
        check({name, "_frame_done"}, done_cnt - done0, exp_done);
        check({name, "_frame_count"}, frame_count, mcount[15:0]);
        check({name, "_busy"}, busy, 1'b0);
    endtask

    task automatic read_check(input string name, input logic [7:0] r);
        logic [15:0] exp;
        exp = (int'(r) < ROWS) ? mbuf[mfront][r] : 16'h0000;
        row = r;
        @(negedge clk);
        check({name, "_pixels"}, pixels, exp);
    endtask

    task automatic randomize_frame();
        for (int i = 0; i < 2*ROWS; i++) fr[i] = 8'($urandom_range(255));
    endtask

    initial begin
        int tx0, done0;

        rvec[0] = '{8'd5,   16'h05FA};
        rvec[1] = '{8'd0,   16'h00FF};
        rvec[2] = '{8'd79,  16'h4FB0};
        rvec[3] = '{8'd40,  16'h28D7};
        rvec[4] = '{8'd80,  16'h0000};
        rvec[5] = '{8'd255, 16'h0000};

        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++) mbuf[b][r] = 16'h0000;

        // Reset state
        reset = 1'b1; rx_strobe = 1'b0; rx_data = 8'h00; row = 8'd0;
        tick(3);
        check("rst_pixels", pixels, 16'h0000);
        check("rst_tx_strobe", tx_strobe, 1'b0);
        reset = 1'b0;
        tick(1);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_count", frame_count, 16'h0000);
        for (int r = 0; r < ROWS; r++) read_check("rst_row", 8'(r));

        // Good frame of {r, ~r}
        for (int r = 0; r < ROWS; r++) begin
            fr[2*r]   = 8'(r);
            fr[2*r+1] = ~8'(r);
        end
        tx0 = tx_cnt; done0 = done_cnt;
        send_frame(1'b0, 2, 2);
        expect_frame("good", tx0, done0, 1, ACK, 1);
        for (int i = 0; i < 6; i++) begin
            row = rvec[i].r;
            @(negedge clk);
            check($sformatf("table_row%0d", rvec[i].r), pixels, rvec[i].exp);
        end

        // Same frame, corrupted checksum: front must not change
        tx0 = tx_cnt; done0 = done_cnt;
        send_frame(1'b1, 2, 2);
        expect_frame("bad_csum", tx0, done0, 1, NAK, 0);
        read_check("bad_csum_row5", 8'd5);
        check("bad_csum_row5_const", pixels, 16'h05FA);

        // Partial frame then timeout, then a good frame
        randomize_frame();
        tx0 = tx_cnt; done0 = done_cnt;
        send_byte(8'hA5, 2);
        send_data(40, 2);
        tick(TIMEOUT - 100);
        check("timeout_busy_before", busy, 1'b1);
        tick(110);
        check("timeout_busy_after", busy, 1'b0);
        check("timeout_no_tx", tx_cnt - tx0, 0);
        check("timeout_no_swap", done_cnt - done0, 0);
        randomize_frame();
        send_frame(1'b0, 1, 2);
        expect_frame("after_timeout", tx0, done0, 1, ACK, 1);
        read_check("after_timeout_row", 8'($urandom_range(ROWS-1)));

        // Garbage before SYNC; SYNC values inside data are plain data
        tx0 = tx_cnt; done0 = done_cnt;
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'h55, 2);
        tick(2);
        check("garbage_busy", busy, 1'b0);
        check("garbage_no_tx", tx_cnt - tx0, 0);
        randomize_frame();
        fr[10] = 8'hA5; fr[11] = 8'hA5; fr[0] = 8'hA5;
        send_frame(1'b0, 2, 2);
        expect_frame("sync_in_data", tx0, done0, 1, ACK, 1);
        read_check("sync_in_data_row5", 8'd5);
        read_check("sync_in_data_row0", 8'd0);

        // Back-to-back SYNC the cycle after a checksum byte
        tx0 = tx_cnt; done0 = done_cnt;
        randomize_frame();
        send_frame(1'b0, 1, 0);
        randomize_frame();
        send_frame(1'b0, 1, 2);
        expect_frame("back_to_back", tx0, done0, 2, ACK, 2);
        read_check("back_to_back_row", 8'($urandom_range(ROWS-1)));

        // Reset mid-frame
        randomize_frame();
        tx0 = tx_cnt; done0 = done_cnt;
        send_byte(8'hA5, 2);
        send_data(100, 2);
        reset = 1'b1;
        mfront = 0;
        mcount = 0;
        tick(2);
        check("midrst_busy", busy, 1'b0);
        check("midrst_pixels", pixels, 16'h0000);
        check("midrst_frame_count", frame_count, 16'h0000);
        reset = 1'b0;
        tick(2);
        check("midrst_no_tx", tx_cnt - tx0, 0);
        read_check("midrst_front_a_row3", 8'd3);
        read_check("midrst_front_a_row60", 8'd60);
        randomize_frame();
        tx0 = tx_cnt; done0 = done_cnt;
        send_frame(1'b0, 2, 2);
        expect_frame("midrst_next", tx0, done0, 1, ACK, 1);
        check("midrst_count_one", frame_count, 16'd1);
        read_check("midrst_next_row7", 8'd7);
        read_check("midrst_next_row79", 8'd79);

        // Randomized frames against the model
        for (int k = 0; k < 12; k++) begin
            bit bad;
            bad = ($urandom_range(3) == 0);
            randomize_frame();
            tx0 = tx_cnt; done0 = done_cnt;
            send_frame(bad, $urandom_range(3), 2);
            expect_frame($sformatf("rand%0d", k), tx0, done0, 1, bad ? NAK : ACK, bad ? 0 : 1);
            read_check($sformatf("rand%0d_row", k), 8'($urandom_range(ROWS + 10)));
        end

        // Out-of-range rows
        read_check("row80", 8'd80);
        read_check("row255", 8'd255);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
